// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmit/receive datapath: word width and
// the transmit-side sequencer state encoding.
package coax_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_WAIT,
        ST_DRAIN
    } tx_state_e;

endpackage

// File: rtl/coax_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is always visible on q.
// A write to a full FIFO is accepted only when a pop happens in the same cycle.
module coax_fifo
    import coax_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = COAX_WORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [WIDTH-1:0]         data,
    input  logic                     read,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_read;
    logic             do_write;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign count    = count_q;
    assign q        = mem_q[rd_ptr_q];
    assign do_read  = read && !empty;
    assign do_write = write && (!full || do_read);

    always_comb begin
        count_d = count_q;
        if (do_write && !do_read) begin
            count_d = count_q + 1'b1;
        end else if (!do_write && do_read) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

endmodule

// File: rtl/coax_buffered_tx.sv
// Host-side word buffer feeding coax_tx: queued words are pushed through the
// transmitter's edge-sensitive load/full handshake as one contiguous frame.
module coax_buffered_tx
    import coax_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COAX_WORD_WIDTH-1:0]   data,
    input  logic                         write,
    input  logic                         start,
    output logic                         busy,
    output logic                         fifo_empty,
    output logic                         fifo_full,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         overflow,
    output logic                         tx_load,
    output logic [COAX_WORD_WIDTH-1:0]   tx_data,
    input  logic                         tx_full,
    input  logic                         tx_active
);

    tx_state_e                  state_q;
    tx_state_e                  state_d;
    logic                       tx_load_q;
    logic [COAX_WORD_WIDTH-1:0] tx_data_q;
    logic                       busy_q;
    logic                       overflow_q;
    logic                       overflow_d;
    logic                       seen_active_q;
    logic [COAX_WORD_WIDTH-1:0] fifo_head;
    logic                       fifo_read;
    logic                       start_ok;
    logic                       write_dropped;

    coax_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COAX_WORD_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .data  (data),
        .read  (fifo_read),
        .q     (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // The head word is latched into tx_data on entry to LOAD and popped during LOAD.
    assign fifo_read     = (state_q == ST_LOAD);
    assign start_ok      = start && (state_q == ST_IDLE) && !fifo_empty;
    assign write_dropped = write && fifo_full && !fifo_read;

    assign tx_load  = tx_load_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = fifo_empty ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (!tx_full && !fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (seen_active_q && !tx_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A dropped write in the same cycle as an accepted start still leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (start_ok) begin
            overflow_d = 1'b0;
        end
        if (write_dropped) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_load_q     <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            seen_active_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_load_q  <= (state_d == ST_LOAD);
            busy_q     <= (state_d != ST_IDLE);
            overflow_q <= overflow_d;
            if (state_d == ST_LOAD) begin
                tx_data_q <= fifo_head;
            end
            if (state_q != ST_DRAIN) begin
                seen_active_q <= 1'b0;
            end else if (tx_active) begin
                seen_active_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coax_buffered_tx.sv
// Directed bench for coax_buffered_tx, driving a small behavioural transmitter
// that mimics coax_tx's load edge detector, holding register and shifter.
module tb_coax_buffered_tx;
    import coax_pkg::*;

    localparam int DEPTH          = 8;
    localparam int CLOCKS_PER_BIT = 8;
    localparam int BITS_PER_WORD  = 12;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] data  = '0;
    logic       write = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       fifo_empty;
    logic       fifo_full;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       tx_load;
    logic [9:0] tx_data;
    logic       tx_full;
    logic       tx_active;

    int vectorCount = 0;
    int missCount   = 0;

    coax_buffered_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .write      (write),
        .start      (start),
        .busy       (busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_active  (tx_active)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: rising load fills the holding register, which moves
    // into the shifter whenever the shifter is idle.
    logic       loadPrev = 1'b0;
    logic       holdFull = 1'b0;
    logic [9:0] holdData = '0;
    int         shiftCnt = 0;

    always @(posedge clk) begin
        loadPrev <= tx_load;
        if (shiftCnt != 0) begin
            shiftCnt <= shiftCnt - 1;
        end else if (holdFull) begin
            shiftCnt <= CLOCKS_PER_BIT * BITS_PER_WORD;
            holdFull <= 1'b0;
        end
        if (tx_load && !loadPrev) begin
            holdData <= tx_data;
            holdFull <= 1'b1;
        end
    end

    assign tx_full   = holdFull;
    assign tx_active = holdFull || (shiftCnt != 0);

    // Monitor: logs every load and tracks handshake rule breaks and edge timing.
    logic [9:0] loadQ[$];
    int  cyc           = 0;
    int  fullViol      = 0;
    int  doubleLoad    = 0;
    int  activeRise    = 0;
    int  activeFallCyc = 0;
    int  busyFallCyc   = 0;
    logic prevLoad   = 1'b0;
    logic prevFull   = 1'b0;
    logic prevActive = 1'b0;
    logic prevBusy   = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_load === 1'b1) begin
            loadQ.push_back(tx_data);
            if (prevLoad) doubleLoad = doubleLoad + 1;
            if (prevFull) fullViol = fullViol + 1;
        end
        if (tx_active && !prevActive) activeRise = activeRise + 1;
        if (!tx_active && prevActive) activeFallCyc = cyc;
        if ((busy === 1'b0) && prevBusy) busyFallCyc = cyc;
        prevLoad   = (tx_load === 1'b1);
        prevFull   = tx_full;
        prevActive = tx_active;
        prevBusy   = (busy === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount = vectorCount + 1;
        if (observed !== expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [9:0] d, input logic w, input logic s);
        data  = d;
        write = w;
        start = s;
        @(negedge clk);
        write = 1'b0;
        start = 1'b0;
    endtask

    task automatic waitLoad(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_load !== 1'b1 && n < 500);
        checkOutput(tag, tx_load, 1'b1);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitTxQuiet();
        int n = 0;
        while (tx_active && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("txQuiet", tx_active, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstLoad",     tx_load,    1'b0);
        checkOutput("rstData",     tx_data,    10'h000);
        checkOutput("rstBusy",     busy,       1'b0);
        checkOutput("rstEmpty",    fifo_empty, 1'b1);
        checkOutput("rstFull",     fifo_full,  1'b0);
        checkOutput("rstCount",    fifo_count, 4'd0);
        checkOutput("rstOverflow", overflow,   1'b0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] async reset in the middle of a frame");
        applyStimulus(10'h155, 1'b1, 1'b0);
        applyStimulus(10'h2AA, 1'b1, 1'b0);
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("midLoad", tx_load, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncLoad",  tx_load,    1'b0);
        checkOutput("asyncData",  tx_data,    10'h000);
        checkOutput("asyncBusy",  busy,       1'b0);
        checkOutput("asyncEmpty", fifo_empty, 1'b1);
        checkOutput("asyncCount", fifo_count, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        waitTxQuiet();
        @(negedge clk);
        loadQ.delete();

        $display("[TB] basic three-word frame");
        applyStimulus(10'h155, 1'b1, 1'b0);
        applyStimulus(10'h2AA, 1'b1, 1'b0);
        applyStimulus(10'h3FF, 1'b1, 1'b0);
        checkOutput("basicCount", fifo_count, 4'd3);
        activeRise = 0;
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("startLatency", tx_load, 1'b1);
        checkOutput("firstData",    tx_data, 10'h155);
        checkOutput("busyRise",     busy,    1'b1);
        waitIdle("basicIdle");
        checkOutput("basicLoads", loadQ.size(), 3);
        checkOutput("basicWord0", loadQ[0], 10'h155);
        checkOutput("basicWord1", loadQ[1], 10'h2AA);
        checkOutput("basicWord2", loadQ[2], 10'h3FF);
        checkOutput("activeOnce", activeRise, 1);
        checkOutput("busyAfterActive", busyFallCyc - activeFallCyc, 1);
        checkOutput("dataHold",   tx_data,    10'h3FF);
        checkOutput("basicEmpty", fifo_empty, 1'b1);

        $display("[TB] overflow with nine writes");
        loadQ.delete();
        for (int i = 0; i < 8; i++) applyStimulus(10'(16 + i), 1'b1, 1'b0);
        checkOutput("ovfFull",    fifo_full,  1'b1);
        checkOutput("ovfCount8",  fifo_count, 4'd8);
        checkOutput("ovfClear",   overflow,   1'b0);
        applyStimulus(10'h018, 1'b1, 1'b0);
        checkOutput("ovfCount9",  fifo_count, 4'd8);
        checkOutput("ovfSet",     overflow,   1'b1);
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("ovfStartClr", overflow, 1'b0);
        waitIdle("ovfIdle");
        checkOutput("ovfLoads", loadQ.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("ovfWord%0d", i), loadQ[i], 10'(16 + i));

        $display("[TB] start with an empty FIFO");
        loadQ.delete();
        applyStimulus(10'h000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("emptyBusy",  busy,         1'b0);
        checkOutput("emptyLoads", loadQ.size(), 0);
        applyStimulus(10'h0AB, 1'b1, 1'b1);
        checkOutput("wrStartBusy",  busy,       1'b0);
        checkOutput("wrStartCount", fifo_count, 4'd1);
        repeat (3) @(negedge clk);
        checkOutput("wrStartLoads", loadQ.size(), 0);
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("wrStartData", tx_data, 10'h0AB);
        waitIdle("wrStartIdle");

        $display("[TB] writes during WAIT and DRAIN");
        loadQ.delete();
        applyStimulus(10'h100, 1'b1, 1'b0);
        applyStimulus(10'h200, 1'b1, 1'b0);
        applyStimulus(10'h300, 1'b1, 1'b0);
        applyStimulus(10'h000, 1'b0, 1'b1);
        waitLoad("load2");
        repeat (2) @(negedge clk);
        applyStimulus(10'h001, 1'b1, 1'b0);
        waitLoad("load3");
        waitLoad("load4");
        checkOutput("waitWordSent", tx_data, 10'h001);
        repeat (2) @(negedge clk);
        applyStimulus(10'h002, 1'b1, 1'b0);
        checkOutput("drainQueued", fifo_count, 4'd1);
        waitIdle("drainIdle");
        checkOutput("frameLoads",  loadQ.size(), 4);
        checkOutput("frameWord3",  loadQ[3],     10'h001);
        repeat (10) @(negedge clk);
        checkOutput("drainHeld",   fifo_count,   4'd1);
        checkOutput("drainNoBusy", busy,         1'b0);
        loadQ.delete();
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("drainWordSent", tx_data, 10'h002);
        waitIdle("drainFrameIdle");
        checkOutput("drainFrameLoads", loadQ.size(), 1);
        checkOutput("drainFrameEmpty", fifo_empty,   1'b1);

        $display("[TB] write plus pop on a full FIFO");
        loadQ.delete();
        for (int i = 0; i < 8; i++) applyStimulus(10'(32 + i), 1'b1, 1'b0);
        checkOutput("fullBefore", fifo_full, 1'b1);
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("fullLoadCycle", tx_load, 1'b1);
        applyStimulus(10'h028, 1'b1, 1'b0);
        checkOutput("pushPopCount",    fifo_count, 4'd8);
        checkOutput("pushPopOverflow", overflow,   1'b0);
        waitIdle("pushPopIdle");
        checkOutput("pushPopLoads", loadQ.size(), 9);
        checkOutput("pushPopFirst", loadQ[0],     10'h020);
        checkOutput("pushPopLast",  loadQ[8],     10'h028);

        checkOutput("loadWhileFull",   fullViol,   0);
        checkOutput("consecutiveLoad", doubleLoad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
